// File: rtl/ccff_bitstream_loader_if.sv
// rtl/ccff_bitstream_loader_if.sv - host stream, configuration chain and status bundle of the loader
// Signals (as seen by the loader, modport slave):
//   start          in   one-cycle load request
//   in_data        in   configuration word, MSB sent first
//   in_valid       in   in_data valid
//   in_ready       out  word accepted when in_valid is also high
//   ccff_head      out  serial bit into the chain
//   ccff_shift_en  out  chain flops capture ccff_head on this edge
//   ccff_tail      in   serial bit leaving the last chain flop
//   rb_data        out  readback word, MSB = first bit out of the tail
//   rb_valid       out  one-cycle readback strobe
//   busy           out  load in progress
//   done           out  one-cycle completion pulse
// The master modport is the host/chain side of the same bundle.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, in_data, in_valid, ccff_tail,
    input  in_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done
  );

  modport slave (
    input  start, in_data, in_valid, ccff_tail,
    output in_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises configuration words onto the ccff chain and captures readback
// Ports:
//   prog_clk    in   programming clock, rising edge
//   prog_reset  in   asynchronous active-high reset
//   bus         ccff_bitstream_loader_if.slave: start, in_data/in_valid/in_ready,
//               ccff_head/ccff_shift_en/ccff_tail, rb_data/rb_valid, busy, done
// Parameters:
//   CHAIN_LEN   configuration flops in the chain
//   WORD_W      width of input and readback words
module ccff_bitstream_loader #(
  parameter  int CHAIN_LEN = 10,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input logic                    prog_clk,
  input logic                    prog_reset,
  ccff_bitstream_loader_if.slave bus
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;    // chain index of the bit currently on ccff_head
  logic [WB_W-1:0]   word_left;  // bits of the current word still to shift, including ccff_head
  logic [WORD_W-1:0] word_buf;   // bits that follow ccff_head, MSB next
  logic [WORD_W-1:0] rb_shift;
  logic [WB_W-1:0]   rb_cnt;

  logic              in_ready_q;
  logic              head_q;
  logic              shift_en_q;
  logic [WORD_W-1:0] rb_data_q;
  logic              rb_valid_q;
  logic              busy_q;
  logic              done_q;

  assign bus.in_ready      = in_ready_q;
  assign bus.ccff_head     = head_q;
  assign bus.ccff_shift_en = shift_en_q;
  assign bus.rb_data       = rb_data_q;
  assign bus.rb_valid      = rb_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

  // Bits of a word that actually reach the chain when its first bit lands at chain index idx;
  // the final word is truncated to what the chain still has room for.
  function automatic logic [WB_W-1:0] word_bits_for(input logic [CNT_W-1:0] idx);
    int left;
    left = CHAIN_LEN - int'(idx);
    if (left > WORD_W) left = WORD_W;
    return WB_W'(left);
  endfunction

  logic              handshake;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_chain_bit;
  logic              ready_mid;
  logic [CNT_W-1:0]  new_idx;
  logic [WB_W-1:0]   new_bits;
  logic              ready_after_load;
  logic [WORD_W-1:0] rb_next;
  logic [WB_W-1:0]   rb_cnt_inc;
  logic [WORD_W-1:0] rb_aligned;

  always_comb begin
    handshake      = bus.in_valid & in_ready_q;
    cnt_inc        = bit_cnt + CNT_W'(1);
    last_chain_bit = (state == S_SHIFT) && (cnt_inc == CNT_W'(CHAIN_LEN));
    // in_ready is registered, so it is raised one cycle ahead for the last bit of a word,
    // which is what lets the next word follow without a bubble.
    ready_mid      = (word_left == WB_W'(2)) && (int'(cnt_inc) + 1 < CHAIN_LEN);
    // A word accepted in LOAD starts at bit_cnt; one accepted on the last bit of the
    // previous word starts one position later.
    new_idx          = (state == S_LOAD) ? bit_cnt : cnt_inc;
    new_bits         = word_bits_for(new_idx);
    ready_after_load = (new_bits == WB_W'(1)) && (int'(new_idx) + 1 < CHAIN_LEN);
    // Readback samples the tail bit present before this edge.
    rb_next    = (rb_shift << 1) | WORD_W'(bus.ccff_tail);
    rb_cnt_inc = rb_cnt + WB_W'(1);
    rb_aligned = rb_next << (WORD_W - int'(rb_cnt_inc));
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      word_left  <= '0;
      word_buf   <= '0;
      rb_shift   <= '0;
      rb_cnt     <= '0;
      in_ready_q <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_LOAD;
            bit_cnt    <= '0;
            rb_shift   <= '0;
            rb_cnt     <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end

        S_LOAD: begin
          if (handshake) begin
            state      <= S_SHIFT;
            shift_en_q <= 1'b1;
            head_q     <= bus.in_data[WORD_W-1];
            word_buf   <= bus.in_data << 1;
            word_left  <= new_bits;
            in_ready_q <= ready_after_load;
          end
        end

        S_SHIFT: begin
          bit_cnt <= cnt_inc;

          // Full readback words are emitted as they complete; the last chain bit also
          // flushes a partial word, so its strobe lands in the FLUSH cycle.
          if (rb_cnt_inc == WB_W'(WORD_W) || last_chain_bit) begin
            rb_data_q  <= rb_aligned;
            rb_valid_q <= 1'b1;
            rb_shift   <= '0;
            rb_cnt     <= '0;
          end else begin
            rb_shift <= rb_next;
            rb_cnt   <= rb_cnt_inc;
          end

          if (word_left != WB_W'(1)) begin
            head_q     <= word_buf[WORD_W-1];
            word_buf   <= word_buf << 1;
            word_left  <= word_left - WB_W'(1);
            in_ready_q <= ready_mid;
          end else if (last_chain_bit) begin
            state      <= S_FLUSH;
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end else if (handshake) begin
            head_q     <= bus.in_data[WORD_W-1];
            word_buf   <= bus.in_data << 1;
            word_left  <= new_bits;
            in_ready_q <= ready_after_load;
          end else begin
            state      <= S_LOAD;
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end

        S_FLUSH: begin
          state  <= S_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - randomized self-checking bench for ccff_bitstream_loader (10- and 16-flop chains)
module tb_ccff_bitstream_loader;

  logic prog_clk = 1'b0;
  logic prog_reset;
  always #5 prog_clk = ~prog_clk;

  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  ccff_bitstream_loader_if #(.WORD_W(8)) a_if ();
  ccff_bitstream_loader_if #(.WORD_W(8)) b_if ();

  ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut_a (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .bus       (a_if.slave)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .bus       (b_if.slave)
  );

  // Both loaders see the same host stream.
  logic [9:0]  chain_a;
  logic [15:0] chain_b;
  logic [9:0]  pre_a;
  logic [15:0] pre_b;
  logic        preload_req;

  assign a_if.start     = start;
  assign a_if.in_data   = in_data;
  assign a_if.in_valid  = in_valid;
  assign a_if.ccff_tail = chain_a[0];
  assign b_if.start     = start;
  assign b_if.in_data   = in_data;
  assign b_if.in_valid  = in_valid;
  assign b_if.ccff_tail = chain_b[0];

  // External chain: bit 0 is the tail-most flop, new bits enter at the head end.
  always @(posedge prog_clk) begin
    if (preload_req) begin
      chain_a <= pre_a;
      chain_b <= pre_b;
    end else begin
      if (a_if.ccff_shift_en) chain_a <= {a_if.ccff_head, chain_a[9:1]};
      if (b_if.ccff_shift_en) chain_b <= {b_if.ccff_head, chain_b[15:1]};
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_clr;
  int          sh_a, sh_b, done_a, done_b, busy_done_a, busy_done_b, coin_a, coin_b;
  int          hs_a, hs_b, stall_sh;
  logic [31:0] head_a, head_b;
  logic [7:0]  rb_a[$];
  logic [7:0]  rb_b[$];

  always @(negedge prog_clk) begin
    if (mon_clr) begin
      sh_a = 0; sh_b = 0; done_a = 0; done_b = 0;
      busy_done_a = 0; busy_done_b = 0; coin_a = 0; coin_b = 0;
      head_a = 0; head_b = 0;
      rb_a.delete(); rb_b.delete();
    end else begin
      if (a_if.ccff_shift_en) begin sh_a++; head_a = {head_a[30:0], a_if.ccff_head}; end
      if (b_if.ccff_shift_en) begin sh_b++; head_b = {head_b[30:0], b_if.ccff_head}; end
      if (a_if.rb_valid) rb_a.push_back(a_if.rb_data);
      if (b_if.rb_valid) rb_b.push_back(b_if.rb_data);
      if (a_if.done) begin done_a++; busy_done_a = int'(a_if.busy); end
      if (b_if.done) begin done_b++; busy_done_b = int'(b_if.busy); end
      if (a_if.done && a_if.rb_valid) coin_a++;
      if (b_if.done && b_if.rb_valid) coin_b++;
    end
  end

  always @(posedge prog_clk) begin
    if (mon_clr) begin
      hs_a = 0; hs_b = 0;
    end else begin
      if (in_valid && a_if.in_ready) hs_a++;
      if (in_valid && b_if.in_ready) hs_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the chain sees the words' bits MSB first, cut to the chain length;
  // packed with the first bit as the MSB of a cl-bit value.
  function automatic logic [31:0] ref_head(input int cl, input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] s;
    s = {w0, w1};
    return 32'(s >> (16 - cl));
  endfunction

  // After a full load the first bit sent sits in the tail-most flop.
  function automatic logic [31:0] ref_chain(input int cl, input logic [31:0] hv);
    logic [31:0] c;
    c = 0;
    for (int k = 0; k < cl; k++) c[k] = hv[cl-1-k];
    return c;
  endfunction

  // Readback word j: old chain contents in tail-first order, grouped by 8, last group left-aligned.
  function automatic logic [7:0] ref_rb_word(input int cl, input logic [31:0] pre, input int j);
    logic [7:0] acc;
    int n;
    acc = 0;
    n = 0;
    for (int k = 8 * j; k < 8 * j + 8 && k < cl; k++) begin
      acc = {acc[6:0], pre[k]};
      n++;
    end
    return acc << (8 - n);
  endfunction

  task automatic clear_mon();
    @(negedge prog_clk);
    mon_clr = 1'b1;
    @(negedge prog_clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int b;
    b = 0;
    while (!a_if.in_ready && b < 100) begin
      @(negedge prog_clk);
      b++;
    end
    if (b >= 100) check({tag, "_ready_timeout"}, 32'(b), 32'd0);
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int gap1,
                          input bit mid_start, input logic [9:0] pa, input logic [15:0] pb);
    int b;
    clear_mon();
    stall_sh = 0;
    pre_a = pa;
    pre_b = pb;
    preload_req = 1'b1;
    @(negedge prog_clk);
    preload_req = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = w0;
    wait_ready("w0");
    @(negedge prog_clk);
    if (mid_start) begin
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
    end
    if (gap1 > 0) begin
      in_valid = 1'b0;
      wait_ready("gap");
      for (int g = 0; g < gap1; g++) begin
        @(negedge prog_clk);
        if (a_if.ccff_shift_en || b_if.ccff_shift_en) stall_sh++;
      end
    end
    in_valid = 1'b1;
    in_data = w1;
    wait_ready("w1");
    @(negedge prog_clk);
    // Keep offering a word: neither loader may take a third one.
    in_data = 8'($urandom);
    b = 0;
    while ((done_a == 0 || done_b == 0) && b < 200) begin
      @(negedge prog_clk);
      b++;
    end
    if (b >= 200) check("done_timeout", 32'(b), 32'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
  endtask

  task automatic check_load(input string t, input logic [7:0] w0, input logic [7:0] w1);
    logic [31:0] ha, hb;
    ha = ref_head(10, w0, w1);
    hb = ref_head(16, w0, w1);
    check({t, "_words_a"}, 32'(hs_a), 32'd2);
    check({t, "_words_b"}, 32'(hs_b), 32'd2);
    check({t, "_shifts_a"}, 32'(sh_a), 32'd10);
    check({t, "_shifts_b"}, 32'(sh_b), 32'd16);
    check({t, "_head_a"}, head_a, ha);
    check({t, "_head_b"}, head_b, hb);
    check({t, "_rbcnt_a"}, 32'(rb_a.size()), 32'd2);
    check({t, "_rbcnt_b"}, 32'(rb_b.size()), 32'd2);
    for (int j = 0; j < 2; j++) begin
      if (j < rb_a.size()) check({t, "_rb_a"}, 32'(rb_a[j]), 32'(ref_rb_word(10, 32'(pre_a), j)));
      if (j < rb_b.size()) check({t, "_rb_b"}, 32'(rb_b[j]), 32'(ref_rb_word(16, 32'(pre_b), j)));
    end
    check({t, "_done_a"}, 32'(done_a), 32'd1);
    check({t, "_done_b"}, 32'(done_b), 32'd1);
    check({t, "_busy_at_done_a"}, 32'(busy_done_a), 32'd0);
    check({t, "_busy_at_done_b"}, 32'(busy_done_b), 32'd0);
    check({t, "_rb_done_overlap_a"}, 32'(coin_a), 32'd0);
    check({t, "_rb_done_overlap_b"}, 32'(coin_b), 32'd0);
    check({t, "_chain_a"}, 32'(chain_a), ref_chain(10, ha));
    check({t, "_chain_b"}, 32'(chain_b), ref_chain(16, hb));
    check({t, "_stall_shift"}, 32'(stall_sh), 32'd0);
  endtask

  function automatic logic [31:0] outs(input logic ir, input logic hd, input logic se,
                                       input logic rv, input logic bs, input logic dn,
                                       input logic [7:0] rd);
    return 32'({ir, hd, se, rv, bs, dn, rd});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w0, w1;
    int cnt;
    prog_reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    preload_req = 1'b0;
    mon_clr = 1'b1;
    pre_a = '0;
    pre_b = '0;
    repeat (3) @(negedge prog_clk);
    check("reset_outs_a", outs(a_if.in_ready, a_if.ccff_head, a_if.ccff_shift_en, a_if.rb_valid,
                               a_if.busy, a_if.done, a_if.rb_data), 32'd0);
    check("reset_outs_b", outs(b_if.in_ready, b_if.ccff_head, b_if.ccff_shift_en, b_if.rb_valid,
                               b_if.busy, b_if.done, b_if.rb_data), 32'd0);
    prog_reset = 1'b0;
    mon_clr = 1'b0;

    // Idle: valid data without start is never taken.
    in_valid = 1'b1;
    in_data = 8'($urandom);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge prog_clk);
      if (a_if.in_ready || b_if.in_ready || a_if.ccff_shift_en || b_if.ccff_shift_en) cnt++;
    end
    check("idle_ready_shift", 32'(cnt), 32'd0);
    in_valid = 1'b0;

    // Nominal load.
    run_load(8'hA5, 8'hC0, 0, 1'b0, 10'b11_0000_0001, 16'($urandom));
    check_load("nom", 8'hA5, 8'hC0);
    check("nom_head_lit", head_a, 32'h297);
    if (rb_a.size() > 0) check("nom_rb0_lit", 32'(rb_a[0]), 32'h80);
    if (rb_a.size() > 1) check("nom_rb1_lit", 32'(rb_a[1]), 32'hC0);

    // Stall of 5 cycles before the second word.
    run_load(8'hA5, 8'hC0, 5, 1'b0, 10'b11_0000_0001, 16'($urandom));
    check_load("stall", 8'hA5, 8'hC0);
    check("stall_head_lit", head_a, 32'h297);

    // Start pulse while busy.
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    run_load(w0, w1, 0, 1'b1, 10'($urandom), 16'($urandom));
    check_load("busy_start", w0, w1);

    // Asynchronous reset after 4 shifted bits.
    clear_mon();
    pre_a = 10'($urandom);
    pre_b = 16'($urandom);
    preload_req = 1'b1;
    @(negedge prog_clk);
    preload_req = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    wait_ready("rst_w0");
    @(negedge prog_clk);
    repeat (3) @(negedge prog_clk);
    @(posedge prog_clk);
    #2 prog_reset = 1'b1;
    #1;
    check("rst_pre_shifts", 32'(sh_a), 32'd4);
    check("rst_outs_a", outs(a_if.in_ready, a_if.ccff_head, a_if.ccff_shift_en, a_if.rb_valid,
                             a_if.busy, a_if.done, a_if.rb_data), 32'd0);
    check("rst_outs_b", outs(b_if.in_ready, b_if.ccff_head, b_if.ccff_shift_en, b_if.rb_valid,
                             b_if.busy, b_if.done, b_if.rb_data), 32'd0);
    in_valid = 1'b0;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      if (a_if.in_ready || a_if.busy || b_if.in_ready || b_if.busy) cnt++;
    end
    check("rst_stays_idle", 32'(cnt), 32'd0);
    in_valid = 1'b0;
    run_load(8'hFF, 8'hFF, 0, 1'b0, 10'($urandom), 16'($urandom));
    check_load("rst_reload", 8'hFF, 8'hFF);
    check("rst_ones_lit", head_a, 32'h3FF);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      run_load(w0, w1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom));
      check_load("rnd", w0, w1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Serialises configuration words from a host-side valid/ready stream onto the configuration chain (ccff_head) that runs through the connection blocks and switch blocks.
- Drives a per-cycle shift enable for the chain flops and captures the bits leaving ccff_tail as readback words.
- Sits directly upstream of the first tile's ccff_head and downstream of the last tile's ccff_tail.

Parameters:
- CHAIN_LEN, 10, total configuration flops in the chain; the default matches one cbx tile (3+3+2+2 bits).
- WORD_W, 8, width of input and readback words.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived, not overridden).

Ports:
- prog_clk  input  1  programming clock; all state updates on the rising edge.
- prog_reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE.
- in_data  input  WORD_W  configuration word; bits are sent MSB first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_shift_en  output  1  chain flops capture ccff_head on this prog_clk edge.
- ccff_tail  input  1  serial bit out of the last chain flop.
- rb_data  output  WORD_W  readback word, MSB = first bit out of the tail.
- rb_valid  output  1  one-cycle pulse, rb_data valid; no backpressure.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the last bit has been shifted.

Behaviour:
- Reset values: in_ready=0, ccff_head=0, ccff_shift_en=0, rb_data=0, rb_valid=0, busy=0, done=0. State is IDLE and all counters and buffers are 0.
- Reset is asynchronous and active-high. When it is asserted mid-load the block returns to IDLE immediately and discards the partial load. Chain contents are then undefined, and software must restart the load.
- States: IDLE, LOAD, SHIFT, FLUSH, DONE.
- IDLE:
  - start=1 moves to LOAD and clears bit_cnt and the readback register.
  - in_valid is ignored.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid & in_ready) loads the word buffer, sets word_bits=min(WORD_W, CHAIN_LEN-bit_cnt), and moves to SHIFT.
  - With no handshake the block stays in LOAD with shift_en=0. Stalls lose no bits.
- SHIFT, each cycle:
  - ccff_shift_en=1 and ccff_head=buffer MSB; buffer shifts left by 1; bit_cnt and readback increment.
  - ccff_tail is sampled into the readback shift register in the same cycle. The sample is the old tail bit, taken before the edge.
- SHIFT, last bit of a word with bits remaining (bit_cnt+1 < CHAIN_LEN):
  - in_ready=1 for that cycle.
  - A handshake gives zero-bubble continuation: the next cycle shifts the new word's MSB. Otherwise the next state is LOAD.
- SHIFT, last chain bit (bit_cnt+1 == CHAIN_LEN): go to FLUSH. in_ready=0.
- Final word: only the top (CHAIN_LEN - bits already sent) bits are shifted; the low bits are discarded.
- Readback:
  - Every WORD_W samples, rb_valid pulses in the cycle after the WORD_W-th sample, with rb_data = the collected bits.
  - FLUSH emits any partial last word, left-aligned and zero-padded, with a one-cycle rb_valid. If the partial count is 0, FLUSH emits nothing. FLUSH always lasts exactly one cycle, then goes to DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- busy is 1 in LOAD, SHIFT and FLUSH.
- start while busy is ignored and has no effect on state.
- ccff_shift_en is never high outside SHIFT. Exactly CHAIN_LEN shift_en cycles occur per completed load.
- Bit order: the first bit shifted ends in the tail-most flop, so bitstream order is last flop first.
- rb_valid and done may coincide only if FLUSH is skipped. That cannot happen, because FLUSH always precedes DONE.

Test Plan:
- Nominal load (CHAIN_LEN=10, WORD_W=8), chain model preloaded with 10'b11_0000_0001 tail-first:
  - Stimulus: start, then words 0xA5 and 0xC0 with in_valid held high.
  - ccff_head over the 10 shift_en cycles must read 1,0,1,0,0,1,0,1,1,1, with no bubble between words.
  - rb_data must be 0x80 then 0xC0 (partial word, zero-padded).
  - done must pulse exactly once, and busy must fall with it.
- Stall: in_valid dropped for 5 cycles before the second word → shift_en stays 0 during the stall, head sequence is identical to the nominal case, and the load totals 10 shift cycles.
- Start while busy: a second start pulse in mid-SHIFT → ignored, no restart; done pulses once.
- Async reset mid-SHIFT after 4 bits → all outputs return to 0 immediately. A following start plus 0xFF, 0xFF gives 10 ones on ccff_head.
- Idle input: in_valid=1 with no start → in_ready stays 0 and shift_en stays 0 for 20 cycles.
- Parameter sweep: CHAIN_LEN=16, WORD_W=8 → exactly 2 words accepted, 2 rb_valid pulses, and FLUSH emits no extra rb_valid.
